// File: rtl/ah_cam_alloc.sv
`default_nettype none
// ============================================================================
// ah_cam_alloc : CAM with hardware slot allocation and lookup-with-release
// Rev 1.0
// ============================================================================
module ah_cam_alloc #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 32,
    parameter  int KW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_an,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_loc,
    input  logic          srch_valid,
    input  logic [KW-1:0] srch_key,
    input  logic          srch_pop,
    output logic          rsp_valid,
    output logic          rsp_hit,
    output logic [AW-1:0] rsp_loc,
    output logic [DW-1:0] rsp_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0][AW-1:0] fifo_mem_q;
    logic [AW:0]              init_cnt_q, init_cnt_d;
    logic [AW-1:0]            fifo_rd_q, fifo_rd_d;
    logic [AW-1:0]            fifo_wr_q, fifo_wr_d;
    logic [AW:0]              fifo_cnt_q, fifo_cnt_d;
    logic [AW:0]              count_q, count_d;
    logic                     rsp_valid_q, rsp_hit_q;
    logic [AW-1:0]            rsp_loc_q;
    logic [DW-1:0]            rsp_data_q;

    logic          w_init_done;
    logic          w_wr_fire;
    logic          w_alloc_pop;
    logic          w_rel_fire;
    logic          w_match_hit;
    logic [AW-1:0] w_match_idx;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == C_LAST) ? '0 : p + AW'(1);
    endfunction

    // Once the init counter saturates, every slot is handed out by the free FIFO.
    assign w_init_done = (init_cnt_q == C_DEPTH);
    assign wr_ready    = !w_init_done || (fifo_cnt_q != '0);
    assign wr_loc      = w_init_done ? fifo_mem_q[fifo_rd_q] : init_cnt_q[AW-1:0];
    assign w_wr_fire   = wr_valid && wr_ready;
    assign w_alloc_pop = w_wr_fire && w_init_done;
    assign w_rel_fire  = srch_valid && srch_pop && w_match_hit;

    // Scan downward so the lowest matching index is the last one kept.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (data_q[i][KW-1:0] == srch_key)) begin
                w_match_hit = 1'b1;
                w_match_idx = AW'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (w_wr_fire)  valid_d[wr_loc]      = 1'b1;
        if (w_rel_fire) valid_d[w_match_idx] = 1'b0;

        init_cnt_d = init_cnt_q;
        if (w_wr_fire && !w_init_done) init_cnt_d = init_cnt_q + (AW+1)'(1);

        fifo_rd_d = w_alloc_pop ? ptr_inc(fifo_rd_q) : fifo_rd_q;
        fifo_wr_d = w_rel_fire  ? ptr_inc(fifo_wr_q) : fifo_wr_q;

        fifo_cnt_d = fifo_cnt_q;
        case ({w_rel_fire, w_alloc_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        count_d = count_q;
        case ({w_wr_fire, w_rel_fire})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            valid_q     <= '0;
            data_q      <= '0;
            fifo_mem_q  <= '0;
            init_cnt_q  <= '0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            fifo_cnt_q  <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_loc_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            init_cnt_q <= init_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            count_q    <= count_d;
            if (w_wr_fire)  data_q[wr_loc]        <= wr_data;
            if (w_rel_fire) fifo_mem_q[fifo_wr_q] <= w_match_idx;
            rsp_valid_q <= srch_valid;
            rsp_hit_q   <= srch_valid && w_match_hit;
            rsp_loc_q   <= (srch_valid && w_match_hit) ? w_match_idx : '0;
            rsp_data_q  <= (srch_valid && w_match_hit) ? data_q[w_match_idx] : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_loc   = rsp_loc_q;
    assign rsp_data  = rsp_data_q;
    assign count     = count_q;
    assign full      = (count_q == C_DEPTH);
    assign empty     = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_ah_cam_alloc.sv
`default_nettype none
// ============================================================================
// tb_ah_cam_alloc : scoreboard bench with a behavioural table/free-list model
// Rev 1.0
// ============================================================================
module tb_ah_cam_alloc;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int KW    = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_an = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_loc;
    logic          srch_valid = 1'b0;
    logic [KW-1:0] srch_key = '0;
    logic          srch_pop = 1'b0;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [AW-1:0] rsp_loc;
    logic [DW-1:0] rsp_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    ah_cam_alloc #(.DEPTH(DEPTH), .DW(DW), .KW(KW)) dut (
        .clk        (clk),
        .rst_an     (rst_an),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_loc     (wr_loc),
        .srch_valid (srch_valid),
        .srch_key   (srch_key),
        .srch_pop   (srch_pop),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_loc    (rsp_loc),
        .rsp_data   (rsp_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [AW-1:0] loc;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          expq[$];
    bit            mvalid[DEPTH];
    logic [DW-1:0] mdata[DEPTH];
    int            alloc_next;
    int            freeq[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(mvalid[i]);
        return n;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            mvalid[i] = 1'b0;
            mdata[i]  = '0;
        end
        alloc_next = 0;
        freeq.delete();
        expq.delete();
    endtask

    // One clock of stimulus: checks the allocation view, predicts the search, updates the model.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic sv,
                         input logic [KW-1:0] sk, input logic sp);
        bit   rdy;
        int   loc;
        int   hit_i;
        rsp_t e;
        wr_valid   = wv;
        wr_data    = wd;
        srch_valid = sv;
        srch_key   = sk;
        srch_pop   = sp;
        @(negedge clk);
        rdy = (alloc_next < DEPTH) || (freeq.size() != 0);
        chk("wr_ready", 64'(wr_ready), 64'(rdy));
        loc = 0;
        if (rdy) begin
            loc = (alloc_next < DEPTH) ? alloc_next : freeq[0];
            chk("wr_loc", 64'(wr_loc), 64'(loc));
        end
        chk("count", 64'(count), 64'(model_count()));
        chk("full",  64'(full),  64'(model_count() == DEPTH));
        chk("empty", 64'(empty), 64'(model_count() == 0));
        hit_i = -1;
        if (sv) begin
            for (int i = 0; i < DEPTH; i++)
                if (hit_i < 0 && mvalid[i] && mdata[i][KW-1:0] == sk) hit_i = i;
            e.hit  = (hit_i >= 0);
            e.loc  = (hit_i >= 0) ? AW'(hit_i) : '0;
            e.data = (hit_i >= 0) ? mdata[hit_i] : '0;
            expq.push_back(e);
        end
        if (wv && rdy) begin
            if (alloc_next < DEPTH) alloc_next++;
            else void'(freeq.pop_front());
            mvalid[loc] = 1'b1;
            mdata[loc]  = wd;
        end
        if (sv && sp && hit_i >= 0) begin
            mvalid[hit_i] = 1'b0;
            freeq.push_back(hit_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Response monitor: every expected response is due exactly one edge after its search.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1));
                chk("rsp_hit",   64'(rsp_hit),   64'(e.hit));
                chk("rsp_loc",   64'(rsp_loc),   64'(e.loc));
                chk("rsp_data",  64'(rsp_data),  64'(e.data));
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        #1 rst_an = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_hit",   64'(rsp_hit),   64'(0));
        chk("rst_rsp_loc",   64'(rsp_loc),   64'(0));
        chk("rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_empty",     64'(empty),     64'(1));
        chk("rst_full",      64'(full),      64'(0));
        chk("rst_wr_ready",  64'(wr_ready),  64'(1));
        chk("rst_wr_loc",    64'(wr_loc),    64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;

        // Fill in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, '0, 1'b0);
        chk("fill_full",     64'(full),     64'(1));
        chk("fill_wr_ready", 64'(wr_ready), 64'(0));
        chk("fill_count",    64'(count),    64'(16));

        // Peek, release, re-search
        cycle(1'b0, '0, 1'b1, 8'd5, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'd7, 1'b1);
        chk("rel7_wr_ready", 64'(wr_ready), 64'(1));
        chk("rel7_wr_loc",   64'(wr_loc),   64'(7));
        chk("rel7_count",    64'(count),    64'(15));
        cycle(1'b0, '0, 1'b1, 8'd7, 1'b0);

        // Free-list ordering
        cycle(1'b1, 32'h0000_01E7, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'd3, 1'b1);
        cycle(1'b0, '0, 1'b1, 8'd9, 1'b1);
        chk("fifo_first", 64'(wr_loc), 64'(3));
        cycle(1'b1, 32'h0000_01E3, 1'b0, '0, 1'b0);
        chk("fifo_second", 64'(wr_loc), 64'(9));
        cycle(1'b1, 32'h0000_01E9, 1'b0, '0, 1'b0);

        // Duplicate keys release lowest first
        cycle(1'b0, '0, 1'b1, 8'd0, 1'b1);
        cycle(1'b0, '0, 1'b1, 8'd1, 1'b1);
        cycle(1'b1, 32'h0000_A02A, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0000_B02A, 1'b0, '0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 8'h2A, 1'b1);

        // Same-cycle write and search
        cycle(1'b1, 32'h0000_C055, 1'b1, 8'h55, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h55, 1'b0);

        // Stalled write against a same-cycle release
        while (model_count() < DEPTH) cycle(1'b1, $urandom, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0000_D077, 1'b1, mdata[0][KW-1:0], 1'b1);
        chk("stall_count", 64'(count), 64'(15));
        cycle(1'b1, 32'h0000_D077, 1'b0, '0, 1'b0);
        chk("stall_refill", 64'(count), 64'(16));

        // Randomised traffic with a small key space to force hits and duplicates
        for (int n = 0; n < 600; n++) begin
            logic [DW-1:0] d;
            d = $urandom;
            d[KW-1:0] = KW'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                  KW'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with a response on the outputs
        cycle(1'b1, 32'h0000_0011, 1'b1, 8'd3, 1'b0);
        chk("mid_rsp_pending", 64'(rsp_valid), 64'(1));
        wr_valid   = 1'b0;
        srch_valid = 1'b0;
        srch_pop   = 1'b0;
        reset_model();
        rst_an = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_count",     64'(count),     64'(0));
        chk("mid_rst_wr_loc",    64'(wr_loc),    64'(0));
        chk("mid_rst_empty",     64'(empty),     64'(1));
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'd2, 1'b0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
